// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, divider step count and divider FSM encoding.
package alu_pkg;

  localparam int WIDTH = 8;
  localparam int DIV_STEPS = 8;
  localparam logic [7:0] DBZ_QUOTIENT = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ABS_A = 3'd1,
    ST_ABS_B = 3'd2,
    ST_DIV   = 3'd3,
    ST_NEG_Q = 3'd4,
    ST_NEG_R = 3'd5,
    ST_DONE  = 3'd6
  } div_state_t;

endpackage

// File: rtl/twosConvertor.sv
// Two's-complement negator shared by every sign conversion step of the divider.
module twosConvertor
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] negated
);

  assign negated = (~value) + WIDTH'(1);

endmodule

// File: rtl/signed_div_seq.sv
// Sequential 8-bit signed divider: magnitude conversion, 8-step restoring divide,
// then sign fix of quotient and remainder, all through one time-shared negator.
module signed_div_seq
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             dbz,
  output logic             ovf,
  output logic             busy
);

  div_state_t       state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] mag_a_r;
  logic [WIDTH-1:0] mag_b_r;
  logic [WIDTH:0]   p_r;
  logic [2:0]       step_r;
  logic             sign_q_r;
  logic             sign_r_r;

  logic [WIDTH-1:0] neg_in_s;
  logic [WIDTH-1:0] neg_out_s;
  logic [WIDTH:0]   p_shift_s;
  logic [WIDTH-1:0] q_shift_s;
  logic [WIDTH+1:0] trial_s;

  // Negator operand select; mag_a_r holds q_mag once the divide has finished.
  always_comb begin
    case (state_r)
      ST_ABS_A: neg_in_s = a_r;
      ST_ABS_B: neg_in_s = b_r;
      ST_NEG_Q: neg_in_s = mag_a_r;
      ST_NEG_R: neg_in_s = p_r[WIDTH-1:0];
      default:  neg_in_s = {WIDTH{1'b0}};
    endcase
  end

  twosConvertor u_neg (
    .value   (neg_in_s),
    .negated (neg_out_s)
  );

  // One restoring step: shift {p, mag_a} left and trial-subtract the divisor magnitude.
  always_comb begin
    p_shift_s = {p_r[WIDTH-1:0], mag_a_r[WIDTH-1]};
    q_shift_s = {mag_a_r[WIDTH-2:0], 1'b0};
    trial_s   = {1'b0, p_shift_s} - {2'b00, mag_b_r};
  end

  assign in_ready = (state_r == ST_IDLE);

  // Divider FSM, step counter, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      mag_a_r   <= {WIDTH{1'b0}};
      mag_b_r   <= {WIDTH{1'b0}};
      p_r       <= {(WIDTH+1){1'b0}};
      step_r    <= 3'd0;
      sign_q_r  <= 1'b0;
      sign_r_r  <= 1'b0;
      out_valid <= 1'b0;
      quotient  <= {WIDTH{1'b0}};
      remainder <= {WIDTH{1'b0}};
      dbz       <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r      <= dividend;
            b_r      <= divisor;
            sign_q_r <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r_r <= dividend[WIDTH-1];
            dbz      <= (divisor == {WIDTH{1'b0}});
            busy     <= 1'b1;
            state_r  <= ST_ABS_A;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_ABS_A: begin
          mag_a_r <= a_r[WIDTH-1] ? neg_out_s : a_r;
          state_r <= ST_ABS_B;
        end
        ST_ABS_B: begin
          mag_b_r <= b_r[WIDTH-1] ? neg_out_s : b_r;
          p_r     <= {(WIDTH+1){1'b0}};
          step_r  <= 3'd0;
          state_r <= ST_DIV;
        end
        ST_DIV: begin
          if (!trial_s[WIDTH+1]) begin
            p_r     <= trial_s[WIDTH:0];
            mag_a_r <= {q_shift_s[WIDTH-1:1], 1'b1};
          end else begin
            p_r     <= p_shift_s;
            mag_a_r <= q_shift_s;
          end
          step_r <= step_r + 3'd1;
          if (step_r == 3'(DIV_STEPS - 1)) begin
            state_r <= ST_NEG_Q;
          end else begin
            state_r <= ST_DIV;
          end
        end
        ST_NEG_Q: begin
          if (dbz) begin
            quotient <= DBZ_QUOTIENT;
            ovf      <= 1'b0;
          end else begin
            // Only -128 / -1 yields a positive magnitude of 128.
            quotient <= sign_q_r ? neg_out_s : mag_a_r;
            ovf      <= !sign_q_r && (mag_a_r == 8'h80);
          end
          state_r <= ST_NEG_R;
        end
        ST_NEG_R: begin
          if (dbz) begin
            remainder <= a_r;
          end else begin
            remainder <= sign_r_r ? neg_out_s : p_r[WIDTH-1:0];
          end
          out_valid <= 1'b1;
          state_r   <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state_r   <= ST_IDLE;
          end else begin
            state_r   <= ST_DONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_signed_div_seq.sv
// Directed and random-vector bench for signed_div_seq with a behavioural division model.
module tb_signed_div_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dividend = 8'h00;
  logic [7:0] divisor = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       dbz;
  logic       ovf;
  logic       busy;

  int tests = 0;
  int fails = 0;

  signed_div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: truncating signed division with the block's special cases.
  task automatic model(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic dz, output logic ov);
    int ia;
    int ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    dz = 1'b0;
    ov = 1'b0;
    if (ib == 0) begin
      q  = 8'hFF;
      r  = a;
      dz = 1'b1;
    end else if (ia == -128 && ib == -1) begin
      q  = 8'h80;
      r  = 8'h00;
      ov = 1'b1;
    end else begin
      q = 8'(ia / ib);
      r = 8'(ia % ib);
    end
  endtask

  // Called #1 after a clock edge; returns #1 after the capture edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic run_txn(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic edz, input logic eov,
                         input bit pulse_busy, input int hold);
    int lat;
    issue(a, b);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (pulse_busy && lat == 4) begin
        in_valid = 1'b1;
        dividend = 8'h80;
        divisor  = 8'hFF;
      end else begin
        in_valid = 1'b0;
      end
      step();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd13);
    check({tag, "_quotient"}, 32'(quotient), 32'(eq));
    check({tag, "_remainder"}, 32'(remainder), 32'(er));
    check({tag, "_dbz"}, 32'(dbz), 32'(edz));
    check({tag, "_ovf"}, 32'(ovf), 32'(eov));
    for (int k = 0; k < hold; k++) begin
      step();
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_hold_q"}, 32'(quotient), 32'(eq));
      check({tag, "_hold_r"}, 32'(remainder), 32'(er));
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_accepted"}, 32'({out_valid, in_ready, busy}), 32'b010);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
  } vec_t;

  vec_t vecs[9] = '{
    '{8'd100, 8'd7,   8'h0E, 8'h02, 1'b0, 1'b0},
    '{8'hF9,  8'h02,  8'hFD, 8'hFF, 1'b0, 1'b0},
    '{8'h07,  8'hFE,  8'hFD, 8'h01, 1'b0, 1'b0},
    '{8'hF9,  8'hFE,  8'h03, 8'hFF, 1'b0, 1'b0},
    '{8'h80,  8'hFF,  8'h80, 8'h00, 1'b0, 1'b1},
    '{8'h80,  8'h01,  8'h80, 8'h00, 1'b0, 1'b0},
    '{8'h37,  8'h00,  8'hFF, 8'h37, 1'b1, 1'b0},
    '{8'h80,  8'h80,  8'h01, 8'h00, 1'b0, 1'b0},
    '{8'h7F,  8'h80,  8'h00, 8'h7F, 1'b0, 1'b0}
  };

  initial begin
    int n;
    int seen;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] mq;
    logic [7:0] mr;
    logic       mdz;
    logic       mov;

    #12;
    check("reset_state", 32'({in_ready, out_valid, busy, dbz, ovf}), 32'b10000);
    check("reset_q_r", 32'({quotient, remainder}), 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    foreach (vecs[i])
      run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
              vecs[i].dz, vecs[i].ov, 1'b0, 0);

    run_txn("hold", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b0, 5);
    run_txn("busy_ignore", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b1, 0);

    // Back-to-back: accept in the cycle out_valid rises with the next request waiting.
    issue(8'd20, 8'd3);
    n = 1;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check("b2b_first_q", 32'({quotient, remainder}), 32'h0602);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    dividend  = 8'hEC;
    divisor   = 8'h03;
    step();
    n++;
    out_ready = 1'b0;
    check("b2b_idle_gap", 32'(busy), 32'd0);
    while (!busy && n < 60) begin
      step();
      n++;
    end
    in_valid = 1'b0;
    // Capture cycles of both requests counted inclusively.
    check("b2b_issue_interval", 32'(n), 32'd15);
    n = 1;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check("b2b_second_latency", 32'(n), 32'd13);
    check("b2b_second_q_r", 32'({quotient, remainder}), 32'hFAFE);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Asynchronous reset while DIV holds step 4.
    issue(8'd100, 8'd7);
    for (int k = 0; k < 6; k++) step();
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_flags", 32'({in_ready, out_valid, busy, dbz, ovf}), 32'b10000);
    check("mid_reset_q_r", 32'({quotient, remainder}), 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid || busy) seen++;
      step();
    end
    check("dropped_txn", 32'(seen), 32'd0);
    run_txn("after_reset", 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom);
      rb = (i % 16 == 0) ? 8'h00 : 8'($urandom);
      model(ra, rb, mq, mr, mdz, mov);
      run_txn($sformatf("rnd_%0h_%0h", ra, rb), ra, rb, mq, mr, mdz, mov, 1'b0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
